// File: rtl/clk_meter_pkg.sv
// Shared types and helpers for the clock period meter.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } meter_state_t;

  // Increment that clamps at sat. This is written at a fixed 32-bit width so
  // that any counter up to 31 bits can be zero-extended into it.
  function automatic logic [31:0] sat_inc(input logic [31:0] count,
                                          input logic [31:0] sat);
    return (count >= sat) ? sat : count + 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchroniser for an asynchronous input, plus a one-cycle-delayed copy
// that is used to detect edges in the clk_in domain.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev;
  assign fall = ~s & prev;

  // Shift sig_in through the synchroniser chain and keep the previous synchronised level.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev   <= s;
    end
  end

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow asynchronous square wave in
// clk_in cycles. It publishes one result per full period and flags an input
// that has stopped toggling.
//
// Handshake: valid is a single-cycle pulse with no ready. period_out and
// high_out change only in the cycle where valid is 1, and they hold between
// pulses.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W:0]   period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic             stuck
);

  localparam logic [31:0]      SAT32 = (32'd1 << CNT_W) - 32'd1;
  localparam logic [CNT_W-1:0] SAT   = SAT32[CNT_W-1:0];

  logic s, rise, fall;

  // FSM state is kept under a plain name so that checkers can bind to it.
  meter_state_t     state, state_nxt;
  logic [CNT_W-1:0] hi_cnt, hi_nxt, hi_inc;
  logic [CNT_W-1:0] lo_cnt, lo_nxt, lo_inc;
  logic             publish, set_stuck;

  // The reset values of the synchroniser look like a low level. Until the
  // chain and the prev flop hold real samples, a high input would show up as
  // a false rising edge. The FSM therefore waits until the chain is primed.
  logic [SYNC_STAGES:0] prime_q;
  logic                 primed;

  assign primed = prime_q[SYNC_STAGES];

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .sig_in (sig_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  assign hi_inc = CNT_W'(sat_inc(32'(hi_cnt), SAT32));
  assign lo_inc = CNT_W'(sat_inc(32'(lo_cnt), SAT32));

  // Fill the priming shift register with ones after reset.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) prime_q <= '0;
    else     prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
  end

  // Next-state, counter and publish decisions; enable low overrides everything.
  always_comb begin
    state_nxt = state;
    hi_nxt    = hi_cnt;
    lo_nxt    = lo_cnt;
    publish   = 1'b0;
    set_stuck = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // Only arm while the input is low, so a partial high phase is never measured.
          if (primed && !s) state_nxt = ARMED;
        end
        ARMED: begin
          if (rise) begin
            state_nxt = HIGH;
            hi_nxt    = CNT_W'(1);
          end
        end
        HIGH: begin
          if (fall) begin
            state_nxt = LOW;
            lo_nxt    = CNT_W'(1);
          end else begin
            hi_nxt = hi_inc;
            if (hi_inc == SAT) begin
              set_stuck = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        LOW: begin
          if (rise) begin
            publish   = 1'b1;
            state_nxt = HIGH;
            hi_nxt    = CNT_W'(1);
          end else begin
            lo_nxt = lo_inc;
            if (lo_inc == SAT) begin
              set_stuck = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else begin
      state  <= state_nxt;
      hi_cnt <= hi_nxt;
      lo_cnt <= lo_nxt;
    end
  end

  // Result registers. stuck is sticky and is cleared only by a good measurement.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      period_out <= '0;
      high_out   <= '0;
      valid      <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      valid <= publish;
      if (publish) begin
        period_out <= {1'b0, hi_cnt} + {1'b0, lo_cnt};
        high_out   <= hi_cnt;
        stuck      <= 1'b0;
      end else if (set_stuck) begin
        stuck <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: square-wave driver, result scoreboard, report.
module tb_clk_period_meter;

  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int EW          = 2 * CNT_W + 1;

  logic             clk_in = 1'b0;
  logic             rst    = 1'b1;
  logic             enable = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W:0]   period_out;
  logic [CNT_W-1:0] high_out;
  logic             valid;
  logic             stuck;

  // Each entry is {period, high}.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_item;
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .enable     (enable),
    .sig_in     (sig_in),
    .period_out (period_out),
    .high_out   (high_out),
    .valid      (valid),
    .stuck      (stuck)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Hold sig_in at level v for n clk_in cycles. Changes land 1 time unit after a posedge.
  task automatic hold(input logic v, input int n);
    sig_in = v;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // One full period: high h, then low l. If exp_en is set, the result is
  // expected when the next rising edge is driven.
  task automatic drive_period(input int h, input int l, input bit exp_en);
    hold(1'b1, h);
    hold(1'b0, l);
    if (exp_en) exp_q.push_back({(CNT_W+1)'(h + l), CNT_W'(h)});
  endtask

  task automatic wait_drain(input string tag);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 100) begin
      @(posedge clk_in);
      #1;
      b++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk_in) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        exp_item = exp_q.pop_front();
        check("period_out", 32'(period_out), 32'(exp_item[EW-1:CNT_W]));
        check("high_out",   32'(high_out),   32'(exp_item[CNT_W-1:0]));
        check("stuck_on_valid", 32'(stuck), 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int h, l;
    enable = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_period", 32'(period_out), 0);
    check("rst_high",   32'(high_out), 0);
    check("rst_valid",  32'(valid), 0);
    check("rst_stuck",  32'(stuck), 0);
    rst = 1'b0;
    hold(1'b0, 5);

    // Regular waveforms, then random ones.
    repeat (6) drive_period(2, 2, 1'b1);
    repeat (4) drive_period(3, 5, 1'b1);
    repeat (4) drive_period(1, 1, 1'b1);
    repeat (4) begin
      h = $urandom_range(1, 6);
      l = $urandom_range(1, 6);
      drive_period(h, l, 1'b1);
    end
    drive_period(3, 4, 1'b1);

    // Input stuck high: the counter saturates and no result is published.
    hold(1'b1, 300);
    wait_drain("drain_run");
    check("stuck_set",         32'(stuck), 1);
    check("stuck_hold_period", 32'(period_out), 7);
    check("stuck_hold_high",   32'(high_out), 3);

    // Toggling resumes, and the first full period clears stuck.
    hold(1'b0, 4);
    drive_period(4, 4, 1'b1);
    check("stuck_sticky", 32'(stuck), 1);
    hold(1'b1, 4);
    check("stuck_cleared", 32'(stuck), 0);
    wait_drain("drain_resume");
    hold(1'b0, 4);

    // Reset pulse while in LOW, with the input high as reset is released.
    rst = 1'b1;
    #2;
    check("arst_period", 32'(period_out), 0);
    check("arst_high",   32'(high_out), 0);
    check("arst_valid",  32'(valid), 0);
    check("arst_stuck",  32'(stuck), 0);
    hold(1'b1, 2);
    rst = 1'b0;
    hold(1'b1, 5);
    hold(1'b0, 3);
    drive_period(2, 3, 1'b1);
    drive_period(5, 2, 1'b1);
    hold(1'b1, 2);
    wait_drain("drain_rst");

    // Enable is dropped mid-HIGH for 10 cycles.
    enable = 1'b0;
    hold(1'b1, 2);
    hold(1'b0, 4);
    hold(1'b1, 4);
    check("dis_hold_period", 32'(period_out), 7);
    check("dis_hold_high",   32'(high_out), 5);
    check("dis_valid",       32'(valid), 0);
    enable = 1'b1;
    hold(1'b1, 2);
    hold(1'b0, 3);
    drive_period(3, 3, 1'b1);
    drive_period(2, 6, 1'b1);
    hold(1'b1, 2);
    wait_drain("drain_enable");
    check("final_stuck", 32'(stuck), 0);
    hold(1'b0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so that the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
